// File: rtl/window_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_packer_pkg
// Description : Shared types and helpers for the window packer / reader pair.
// Revision    : 1.0 - initial release
// ============================================================================
package window_packer_pkg;

   localparam logic [0:0] c_st_fill = 1'b0;
   localparam logic [0:0] c_st_full = 1'b1;

   typedef enum logic [0:0] {
      FILL = c_st_fill,
      FULL = c_st_full
   } pack_state_t;

   // Counter width able to hold 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/window_packer.sv
`default_nettype none
// ============================================================================
// Module      : window_packer
// Description : Packs a scalar sample stream into WINDOW_SIZE-wide windows.
// Revision    : 1.0 - initial release
// ============================================================================
module window_packer
   import window_packer_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int WINDOW_SIZE = 32,
   parameter int CNT_W       = cnt_width(WINDOW_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] in_sample,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] out_window [0:WINDOW_SIZE-1],
   output logic [CNT_W-1:0]             out_count,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WINDOW_SIZE - 1);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   pack_state_t                  r_state;
   logic signed [DATA_WIDTH-1:0] r_fill_buf   [0:WINDOW_SIZE-1];
   logic signed [DATA_WIDTH-1:0] r_out_window [0:WINDOW_SIZE-1];
   logic [CNT_W-1:0]             r_wr_idx;
   logic [CNT_W-1:0]             r_hold_count;
   logic [CNT_W-1:0]             r_out_count;
   logic                         r_out_valid;

   logic                         w_accept;
   logic                         w_close;
   logic                         w_slot_free;
   logic                         w_xfer;
   logic [CNT_W-1:0]             w_xfer_count;
   logic signed [DATA_WIDTH-1:0] w_buf_next    [0:WINDOW_SIZE-1];
   logic signed [DATA_WIDTH-1:0] w_xfer_window [0:WINDOW_SIZE-1];

   assign in_ready     = (r_state == FILL) && !rst;
   assign w_accept     = in_valid && in_ready;
   assign w_close      = w_accept && ((r_wr_idx == c_last_idx) || in_last);
   assign w_slot_free  = !r_out_valid || out_ready;
   // Either a fresh close or a held window moves into the output register.
   assign w_xfer       = w_slot_free && (w_close || (r_state == FULL));
   assign w_xfer_count = (r_state == FULL) ? r_hold_count : (r_wr_idx + c_one);

   assign out_count    = r_out_count;
   assign out_valid    = r_out_valid;

   generate
      for (genvar i = 0; i < WINDOW_SIZE; i++) begin : g_lane
         assign w_buf_next[i]    = (w_accept && (r_wr_idx == CNT_W'(i))) ? in_sample
                                                                         : r_fill_buf[i];
         assign w_xfer_window[i] = (CNT_W'(i) < w_xfer_count) ? w_buf_next[i] : '0;
         assign out_window[i]    = r_out_window[i];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= FILL;
         r_wr_idx     <= '0;
         r_hold_count <= '0;
         r_out_count  <= '0;
         r_out_valid  <= 1'b0;
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            r_fill_buf[i]   <= '0;
            r_out_window[i] <= '0;
         end
      end else if (w_xfer) begin
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            r_out_window[i] <= w_xfer_window[i];
            r_fill_buf[i]   <= '0;
         end
         r_out_count <= w_xfer_count;
         r_out_valid <= 1'b1;
         r_wr_idx    <= '0;
         r_state     <= FILL;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            for (int i = 0; i < WINDOW_SIZE; i++) begin
               r_fill_buf[i] <= w_buf_next[i];
            end
         end
         // A close that cannot reach the output parks the window in FULL.
         if (w_close) begin
            r_hold_count <= r_wr_idx + c_one;
            r_state      <= FULL;
         end else if (w_accept) begin
            r_wr_idx <= r_wr_idx + c_one;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_window_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_packer
// Description : Directed and randomized checks of window_packer (WINDOW_SIZE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_packer;

   localparam int DW = 16;
   localparam int WS = 4;
   localparam int CW = 3;

   typedef struct {
      logic [DW*WS-1:0] win;
      int               cnt;
   } win_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] in_sample;
   logic                 in_valid;
   logic                 in_last;
   logic                 in_ready;
   logic signed [DW-1:0] out_window [0:WS-1];
   logic [CW-1:0]        out_count;
   logic                 out_valid;
   logic                 out_ready;

   window_packer #(
      .DATA_WIDTH (DW),
      .WINDOW_SIZE(WS),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_sample (in_sample),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_window(out_window),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: completed windows wait in done_q until the output slot frees.
   logic [DW*WS-1:0]     m_win;
   int                   m_cnt;
   logic                 m_valid;
   logic                 m_in_ready;
   logic signed [DW-1:0] part_q [$];
   win_t                 done_q [$];
   logic signed [DW-1:0] acc_q  [$];
   logic signed [DW-1:0] rx_q   [$];

   function automatic logic [DW*WS-1:0] dut_flat();
      logic [DW*WS-1:0] f;
      for (int i = 0; i < WS; i++) f[i*DW +: DW] = out_window[i];
      return f;
   endfunction

   task automatic check(input string tag, input logic [DW*WS-1:0] got,
                        input logic [DW*WS-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"},  64'(out_valid), 64'(m_valid));
      check({tag, ".out_count"},  64'(out_count), 64'(m_cnt));
      check({tag, ".out_window"}, dut_flat(), m_win);
      check({tag, ".in_ready"},   64'(in_ready), 64'(m_in_ready));
   endtask

   task automatic model_reset(input logic ready_after);
      m_win      = '0;
      m_cnt      = 0;
      m_valid    = 1'b0;
      m_in_ready = ready_after;
      part_q.delete();
      done_q.delete();
      acc_q.delete();
      rx_q.delete();
   endtask

   task automatic model_edge(input logic v, input logic signed [DW-1:0] s,
                             input logic l, input logic ordy);
      logic slot_free;
      win_t w;
      slot_free = !m_valid || ordy;
      if (m_valid && ordy) m_valid = 1'b0;
      if (v && m_in_ready) begin
         acc_q.push_back(s);
         part_q.push_back(s);
         if (part_q.size() == WS || l) begin
            w.win = '0;
            foreach (part_q[i]) w.win[i*DW +: DW] = part_q[i];
            w.cnt = part_q.size();
            done_q.push_back(w);
            part_q.delete();
         end
      end
      if (done_q.size() != 0 && slot_free) begin
         w       = done_q.pop_front();
         m_win   = w.win;
         m_cnt   = w.cnt;
         m_valid = 1'b1;
      end
      m_in_ready = (done_q.size() == 0);
   endtask

   // One clock: drive in the low phase, step the model at the edge, check at negedge.
   task automatic cycle(input string tag, input logic v, input logic signed [DW-1:0] s,
                        input logic l, input logic ordy);
      in_valid  = v;
      in_sample = s;
      in_last   = l;
      out_ready = ordy;
      if (out_valid && ordy) begin
         for (int i = 0; i < int'(out_count) && i < WS; i++) rx_q.push_back(out_window[i]);
      end
      @(posedge clk);
      model_edge(v, s, l, ordy);
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      logic signed [DW-1:0] ext [0:3];
      rst = 1'b1;
      in_valid = 1'b0; in_sample = '0; in_last = 1'b0; out_ready = 1'b0;
      model_reset(1'b0);
      @(negedge clk);
      check_outputs("reset");
      rst = 1'b0;
      m_in_ready = 1'b1;
      #1 check_outputs("post_reset");

      // Full window with a ready consumer.
      for (int i = 1; i <= 4; i++) cycle("t1_fill", 1'b1, 16'(i), 1'b0, 1'b1);
      cycle("t1_idle", 1'b0, '0, 1'b0, 1'b1);
      cycle("t1_idle", 1'b0, '0, 1'b0, 1'b1);

      // Backpressure: second window parks until the consumer pulses ready.
      for (int i = 1; i <= 8; i++) cycle("t2_fill", 1'b1, 16'(i), 1'b0, 1'b0);
      cycle("t2_hold", 1'b1, 16'd99, 1'b0, 1'b0);
      cycle("t2_hold", 1'b0, '0, 1'b0, 1'b0);
      cycle("t2_pulse", 1'b0, '0, 1'b0, 1'b1);
      cycle("t2_after", 1'b0, '0, 1'b0, 1'b0);
      cycle("t2_drain", 1'b0, '0, 1'b0, 1'b1);

      // Early close, stray in_last, and a single-sample window.
      cycle("t3_early", 1'b1, 16'sd9, 1'b0, 1'b1);
      cycle("t3_early", 1'b1, -16'sd3, 1'b1, 1'b1);
      cycle("t3_stray", 1'b0, 16'sd5, 1'b1, 1'b1);
      cycle("t3_one", 1'b1, 16'sd7, 1'b1, 1'b1);
      for (int i = 10; i <= 13; i++) cycle("t3_next", 1'b1, 16'(i), 1'b0, 1'b1);
      cycle("t3_idle", 1'b0, '0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a partial window.
      for (int i = 1; i <= 3; i++) cycle("t4_part", 1'b1, 16'(i + 20), 1'b0, 1'b1);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      model_reset(1'b0);
      #1 check_outputs("t4_async");
      @(negedge clk);
      @(negedge clk);
      check_outputs("t4_held");
      rst = 1'b0;
      m_in_ready = 1'b1;
      #1 check_outputs("t4_release");
      for (int i = 5; i <= 8; i++) cycle("t4_fill", 1'b1, 16'(i), 1'b0, 1'b1);
      cycle("t4_idle", 1'b0, '0, 1'b0, 1'b1);

      // Extreme values pass through bit-exact.
      ext[0] = -16'sd32768; ext[1] = 16'sd32767; ext[2] = -16'sd1; ext[3] = 16'sd0;
      for (int i = 0; i < 4; i++) cycle("t5_ext", 1'b1, ext[i], 1'b0, 1'b1);
      cycle("t5_idle", 1'b0, '0, 1'b0, 1'b1);

      // Sustained streaming, then random traffic with stalls.
      for (int i = 0; i < 12; i++) cycle("t6_stream", 1'b1, 16'(100 + i), 1'b0, 1'b1);
      for (int n = 0; n < 400; n++) begin
         cycle("t6_rand", ($urandom % 4) != 0, 16'($urandom), ($urandom % 8) == 0,
               ($urandom % 3) != 0);
      end
      for (int n = 0; n < 8; n++) cycle("t6_drain", 1'b0, '0, 1'b0, 1'b1);

      check("sb_count", 64'(rx_q.size()), 64'(acc_q.size()));
      for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
         check("sb_sample", 64'(rx_q[i]), 64'(acc_q[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/window_packer.md
Name: window_packer

Overview:
Inverse of window_reader: collects a scalar sample stream into WINDOW_SIZE-wide window vectors for blocks that consume whole windows, such as attention and fusion back-ends. It sits on the output side of the feature-extraction chain.
It accepts samples with a valid/ready handshake and supports early window close via in_last. One fill buffer plus one output register allow back-to-back windows at one sample per cycle.

Parameters:
DATA_WIDTH, 16, sample width (signed two's complement)
WINDOW_SIZE, 32, samples per window (>= 2)
CNT_W, $clog2(WINDOW_SIZE+1), derived; width of out_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_sample  input  DATA_WIDTH signed  stream sample
in_valid  input  1  sample present
in_last  input  1  closes window after this sample; qualified by in_valid
in_ready  output  1  packer can accept a sample
out_window  output  DATA_WIDTH signed x [0:WINDOW_SIZE-1]  packed window; index 0 = oldest sample
out_count  output  CNT_W  number of valid samples in out_window (1..WINDOW_SIZE)
out_valid  output  1  window available
out_ready  input  1  consumer accepts window

Behaviour:
- Reset (async, active-high):
  - out_window, out_count and out_valid = 0.
  - fill buffer cleared; wr_idx = 0; state = FILL; in_ready = 0 during reset.
  - Any partial or pending windows are discarded, including on reset mid-operation.
- Accept: a sample is taken when in_valid && in_ready. It is written to fill_buf[wr_idx], then wr_idx++.
- in_ready = (state == FILL). It is combinational from state only and has no dependency on out_ready.
- Close event: an accepted sample with wr_idx == WINDOW_SIZE-1 or in_last = 1.
- Output slot free: defined as (!out_valid || out_ready).
- FILL state:
  - Close event with slot free:
    - next cycle, out_window = fill contents including the closing sample, with entries at index >= count forced to 0;
    - out_count = wr_idx+1; out_valid = 1;
    - fill buffer cleared; wr_idx = 0; stay in FILL.
  - Latency is exactly 1 cycle from the closing sample's accept edge to out_valid.
  - Close event with slot not free: store the sample, latch the count, go to FULL.
- FULL state:
  - in_ready = 0.
  - When the slot is free, transfer the held window to the output register (same zero-fill and count rules).
  - Then clear the fill buffer, set wr_idx = 0 and go to FILL; in_ready rises the following cycle.
- Output hold: while out_valid && !out_ready, out_window and out_count stay stable. out_valid drops after a handshake unless a new window transfers on that same edge.
- Simultaneous out handshake and close event: the new window replaces the old one on the same edge, with no bubble.
- Throughput: with out_ready held at 1, one sample per cycle is sustained and in_ready never deasserts.
- in_last while in_valid = 0 is ignored. in_last on the first sample produces a window with out_count = 1.
- Samples pass through bit-exact; no arithmetic and no saturation.

Decomposition:
- Shared package:
  - pack_state_t enum {FILL, FULL};
  - the CNT_W derivation function (shared with window_reader's index counter).
- No sub-module. The fill buffer, index counter and output register are a single sequential block plus a 2-state FSM.

Test Plan:
1. WINDOW_SIZE=4, out_ready=1, samples 1,2,3,4 on consecutive cycles -> out_valid for 1 cycle, 1 cycle after the 4th accept; out_window={1,2,3,4}; out_count=4; in_ready stays 1.
2. Backpressure, out_ready=0, samples 1..8 -> window {1,2,3,4} is held stable. in_ready drops after the 8th accept and the FSM is in FULL. Pulse out_ready for 1 cycle -> next cycle out_window={5,6,7,8}, out_valid=1, in_ready=1.
3. Early close: samples 9, -3 with in_last on -3 -> out_window={9,-3,0,0}, out_count=2. The next window starts at index 0.
4. Reset asserted asynchronously after 3 of 4 samples -> all outputs 0 immediately. Post-reset samples 5,6,7,8 -> out_window={5,6,7,8}, with no stale data.
5. Extremes: -32768, 32767, -1, 0 -> output bit-exact, same order, out_count=4.
6. Streaming 12 samples with out_ready=1 and in_valid=1 every cycle -> 3 out_valid pulses spaced 4 cycles apart, in_ready constantly 1. Random out_ready stalls produce no lost or duplicated samples (checked with a scoreboard).
